// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the eFPGA configuration frame loader.
// CHECK exists only when CFG_LOADER_CHECKSUM_EN is defined.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
`ifdef CFG_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_ERR
  } state_e;

  localparam int HDR_COL_MSB   = 31;
  localparam int HDR_COL_LSB   = 24;
  localparam int HDR_START_MSB = 23;
  localparam int HDR_START_LSB = 16;
  localparam int HDR_CNT_MSB   = 15;
  localparam int HDR_CNT_LSB   = 0;

  localparam logic [15:0] END_MARKER_CNT = 16'd0;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame pointer plus enable to a registered one-hot latch strobe.
// Out-of-range pointers produce no strobe.
module frame_strobe_decoder #(
  parameter int MAX_FRAMES = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            ptr,
  input  logic                  en,
  output logic [MAX_FRAMES-1:0] frame_strobe
);

  logic [MAX_FRAMES-1:0] onehot;

  always_comb begin
    onehot = '0;
    if (en && (32'(ptr) < MAX_FRAMES))
      onehot = MAX_FRAMES'(1) << ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_strobe <= '0;
    else
      frame_strobe <= onehot;
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// eFPGA configuration frame loader: sync, column headers, frame strobes.
// Define CFG_LOADER_CHECKSUM_EN to add the trailing XOR checksum word.
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int          NUM_COLUMNS   = 16,
  parameter int          MAX_FRAMES    = 20,
  parameter int          STROBE_CYCLES = 2,
  parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [31:0]            frame_data,
  output logic [NUM_COLUMNS-1:0] frame_col,
  output logic [MAX_FRAMES-1:0]  frame_strobe,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_err
);

  localparam int SCW =
    (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(STROBE_CYCLES - 1);

  state_e         state;
  logic           run_q;
  logic [7:0]     ptr_q;
  logic [15:0]    rem_q;
  logic [SCW-1:0] scnt_q;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [31:0]    acc_q;
`endif

  logic        fire;
  logic        is_sync;
  logic [7:0]  hdr_col;
  logic [7:0]  hdr_start;
  logic [15:0] hdr_cnt;
  logic [16:0] hdr_end;
  logic        hdr_bad;
  logic        strobe_en;

  assign s_ready = run_q &
    !(state inside {ST_SETUP, ST_STROBE, ST_HOLD});
  assign busy    = !(state inside {ST_IDLE, ST_ERR});
  assign fire    = s_valid & s_ready;
  assign is_sync = (s_data == SYNC_WORD);

  assign hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
  assign hdr_start = s_data[HDR_START_MSB:HDR_START_LSB];
  assign hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  // 17 bits so start+count cannot wrap past the frame limit
  assign hdr_end   = 17'(hdr_start) + 17'(hdr_cnt);
  assign hdr_bad   = (32'(hdr_col) >= NUM_COLUMNS) ||
                     (32'(hdr_end) > MAX_FRAMES);

  // Strobe register follows this by one cycle, so it covers STROBE only
  assign strobe_en = (state == ST_SETUP) ||
                     ((state == ST_STROBE) && (scnt_q != SC_LAST));

  frame_strobe_decoder #(
    .MAX_FRAMES (MAX_FRAMES)
  ) u_dec (
    .clk          (CLK),
    .rst_n        (resetn),
    .ptr          (ptr_q),
    .en           (strobe_en),
    .frame_strobe (frame_strobe)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      run_q      <= 1'b0;
      ptr_q      <= '0;
      rem_q      <= '0;
      scnt_q     <= '0;
      frame_data <= '0;
      frame_col  <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      run_q    <= 1'b1;
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (fire && is_sync) begin
            state   <= ST_HEADER;
            cfg_err <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        ST_HEADER: begin
          if (fire) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            acc_q <= acc_q ^ s_data;
`endif
            if (hdr_cnt == END_MARKER_CNT) begin
`ifdef CFG_LOADER_CHECKSUM_EN
              state     <= ST_CHECK;
`else
              state     <= ST_IDLE;
              frame_col <= '0;
              cfg_done  <= 1'b1;
`endif
            end else if (hdr_bad) begin
              state     <= ST_ERR;
              frame_col <= '0;
              cfg_err   <= 1'b1;
            end else begin
              state     <= ST_DATA;
              frame_col <= NUM_COLUMNS'(1) << hdr_col;
              ptr_q     <= hdr_start;
              rem_q     <= hdr_cnt;
            end
          end
        end
        ST_DATA: begin
          if (fire) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            acc_q <= acc_q ^ s_data;
`endif
            frame_data <= s_data;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          scnt_q <= '0;
          state  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (scnt_q == SC_LAST)
            state <= ST_HOLD;
          else
            scnt_q <= scnt_q + 1'b1;
        end
        ST_HOLD: begin
          ptr_q <= ptr_q + 8'd1;
          rem_q <= rem_q - 16'd1;
          state <= (rem_q == 16'd1) ? ST_HEADER : ST_DATA;
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (fire) begin
            frame_col <= '0;
            if (s_data == acc_q) begin
              state    <= ST_IDLE;
              cfg_done <= 1'b1;
            end else begin
              state   <= ST_ERR;
              cfg_err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          frame_col <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed self-checking bench for cfg_frame_loader.
// Checksum scenarios run when CFG_LOADER_CHECKSUM_EN is defined.
module tb_cfg_frame_loader;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] frame_data;
  logic [15:0] frame_col;
  logic [19:0] frame_strobe;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [19:0] stb;
    logic [31:0] dat;
  } ent_t;

  ent_t        sq[$];
  int          done_cnt = 0;
  int          viol = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] prev_dat = '0;

  cfg_frame_loader dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .frame_data   (frame_data),
    .frame_col    (frame_col),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  always #5 CLK = ~CLK;

  // Strobe trace, done pulses and one-hot/stability violations
  always @(negedge CLK) begin
    if (!resetn) begin
      sq.delete();
      done_cnt = 0;
      viol = 0;
      prev_stb = 1'b0;
    end else begin
      if (frame_strobe != '0) begin
        sq.push_back('{stb: frame_strobe, dat: frame_data});
        if ($countones(frame_strobe) != 1) viol++;
        if (prev_stb && (frame_data != prev_dat)) viol++;
      end
      if (cfg_done) done_cnt++;
      prev_stb = |frame_strobe;
      prev_dat = frame_data;
    end
  end

  task automatic do_reset;
    resetn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(posedge CLK);
    #1 resetn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    s_data = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    n_chk++;
    if (!s_ready) begin
      n_fail++;
      $display("FAIL send_timeout word=%h s_ready=%b want 1", w, s_ready);
    end
    @(posedge CLK);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_end(input logic [31:0] csum);
    send(32'h0000_0000);
`ifdef CFG_LOADER_CHECKSUM_EN
    send(csum);
`else
    if (csum === 32'hx) $display("unused");
`endif
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hFAB0_FAB1;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if ({s_ready, busy, cfg_done, cfg_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 0000",
               {s_ready, busy, cfg_done, cfg_err});
    end
    n_chk++;
    if ({frame_data, frame_col, frame_strobe} !== '0) begin
      n_fail++;
      $display("FAIL rst_buses data=%h col=%h stb=%h want 0",
               frame_data, frame_col, frame_strobe);
    end
    s_valid = 1'b0;
    resetn = 1'b1;
    @(posedge CLK);
    #1;
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release rdy=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_normal_load;
    logic [19:0] es[4];
    logic [31:0] ed[4];
    es = '{20'h00001, 20'h00001, 20'h00002, 20'h00002};
    ed = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    do_reset();
    send(32'hFAB0_FAB1);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL norm_busy got %b want 1", busy);
    end
    send(32'h0200_0002);
    n_chk++;
    if (frame_col !== 16'h0004) begin
      n_fail++;
      $display("FAIL norm_col got %h want 0004", frame_col);
    end
    send(32'hA5A5_A5A5);
    send(32'h5A5A_5A5A);
    send_end(32'hFDFF_FFFD);
    n_chk++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL norm_done got %b want 1", cfg_done);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL norm_done_cnt got %0d want 1", done_cnt);
    end
    n_chk++;
    if (frame_col !== 16'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL norm_idle col=%h busy=%b want 0 0", frame_col, busy);
    end
    n_chk++;
    if (sq.size() != 4) begin
      n_fail++;
      $display("FAIL norm_stb_len got %0d want 4", sq.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < sq.size()) begin
        n_chk++;
        if (sq[i].stb !== es[i] || sq[i].dat !== ed[i]) begin
          n_fail++;
          $display("FAIL norm_stb%0d got %h/%h want %h/%h",
                   i, sq[i].stb, sq[i].dat, es[i], ed[i]);
        end
      end
    end
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL norm_viol got %0d want 0", viol);
    end
  endtask

  task automatic test_bad_header;
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'h1000_0001);
    n_chk++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || frame_col !== 16'h0) begin
      n_fail++;
      $display("FAIL bad_col err=%b busy=%b col=%h want 1 0 0",
               cfg_err, busy, frame_col);
    end
    send(32'h0000_0001);
    send(32'h1234_5678);
    send(32'h0000_0000);
    repeat (6) @(posedge CLK);
    #1;
    n_chk++;
    if (sq.size() != 0 || cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_drop stb=%0d err=%b want 0 1", sq.size(), cfg_err);
    end
    send(32'hFAB0_FAB1);
    n_chk++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_resync err=%b busy=%b want 0 1", cfg_err, busy);
    end
    send_end(32'h0000_0000);
    n_chk++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_done got %b want 1", cfg_done);
    end
  endtask

  task automatic test_frame_bounds;
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'h0F13_0001);
    n_chk++;
    if (frame_col !== 16'h8000 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_col col=%h err=%b want 8000 0", frame_col, cfg_err);
    end
    send(32'hDEAD_BEEF);
    send_end(32'hD1BE_BEEE);
    n_chk++;
    if (sq.size() != 2) begin
      n_fail++;
      $display("FAIL bnd_len got %0d want 2", sq.size());
    end else begin
      n_chk++;
      if (sq[1].stb !== 20'h80000 || sq[1].dat !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL bnd_stb got %h/%h want 80000/deadbeef",
                 sq[1].stb, sq[1].dat);
      end
    end
    send(32'hFAB0_FAB1);
    send(32'h0113_0002);
    repeat (6) @(posedge CLK);
    #1;
    n_chk++;
    if (cfg_err !== 1'b1 || sq.size() != 2) begin
      n_fail++;
      $display("FAIL bnd_range err=%b stb=%0d want 1 2", cfg_err, sq.size());
    end
  endtask

  task automatic test_backpressure;
    int nr;
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      s_valid = i[0];
      s_data = 32'h0BAD_0000 | i;
      if (i[0]) s_valid = 1'b0;
      @(posedge CLK);
      #1;
    end
    n_chk++;
    if (sq.size() != 0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_gap stb=%0d rdy=%b want 0 1", sq.size(), s_ready);
    end
    send(32'h1111_2222);
    nr = 0;
    n_chk++;
    if (frame_data !== 32'h1111_2222 || frame_strobe !== '0) begin
      n_fail++;
      $display("FAIL bp_setup data=%h stb=%h want 11112222 0",
               frame_data, frame_strobe);
    end
    for (int c = 0; c < 4; c++) begin
      if (!s_ready) nr++;
      if (c == 1 || c == 2) begin
        n_chk++;
        if (frame_strobe !== 20'h00001) begin
          n_fail++;
          $display("FAIL bp_strobe%0d got %h want 00001", c, frame_strobe);
        end
      end
      @(posedge CLK);
      #1;
    end
    n_chk++;
    if (nr != 4 || s_ready !== 1'b1 || frame_strobe !== '0) begin
      n_fail++;
      $display("FAIL bp_ready_lo cnt=%0d rdy=%b stb=%h want 4 1 0",
               nr, s_ready, frame_strobe);
    end
    send_end(32'h1111_2223);
    n_chk++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done got %b want 1", cfg_done);
    end
  endtask

  task automatic test_reset_mid_strobe;
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'h0300_0002);
    send(32'hCAFE_F00D);
    @(posedge CLK);
    #1;
    n_chk++;
    if (frame_strobe !== 20'h00001) begin
      n_fail++;
      $display("FAIL mid_pre got %h want 00001", frame_strobe);
    end
    #1 resetn = 1'b0;
    #1;
    n_chk++;
    if (frame_strobe !== '0 || frame_col !== '0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async stb=%h col=%h rdy=%b want 0 0 0",
               frame_strobe, frame_col, s_ready);
    end
    repeat (2) @(posedge CLK);
    #1 resetn = 1'b1;
    @(posedge CLK);
    #1;
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || frame_col !== '0) begin
      n_fail++;
      $display("FAIL mid_idle rdy=%b busy=%b col=%h want 1 0 0",
               s_ready, busy, frame_col);
    end
    send(32'h1234_5678);
    repeat (6) @(posedge CLK);
    #1;
    n_chk++;
    if (sq.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_noresume stb=%0d busy=%b want 0 0", sq.size(), busy);
    end
  endtask

`ifdef CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'h0100_0001);
    send(32'h0F0F_0000);
    send(32'h0000_0000);
    send(32'h0E0F_0001);
    n_chk++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cks_good done=%b err=%b want 1 0", cfg_done, cfg_err);
    end
    send(32'hFAB0_FAB1);
    send(32'h0100_0001);
    send(32'h0F0F_0000);
    send(32'h0000_0000);
    send(32'h0E0F_0000);
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if (cfg_err !== 1'b1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL cks_bad err=%b dones=%0d want 1 1", cfg_err, done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_load();
    test_bad_header();
    test_frame_bounds();
    test_backpressure();
    test_reset_mid_strobe();
`ifdef CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
